// File: rtl/i2c_poller_pkg.sv
// Shared definitions for the i2c sensor poller: core command codes, status bit
// positions and the state encodings of the transaction and byte-op sequencers.
package i2c_poller_pkg;

    localparam logic [7:0] CMD_START_WR     = 8'h90;
    localparam logic [7:0] CMD_WR           = 8'h10;
    localparam logic [7:0] CMD_WR_STOP      = 8'h50;
    localparam logic [7:0] CMD_RD_ACK       = 8'h20;
    localparam logic [7:0] CMD_RD_NACK_STOP = 8'h68;
    localparam logic [7:0] CMD_STOP         = 8'h40;

    localparam int unsigned STAT_BUSY = 7;
    localparam int unsigned STAT_NACK = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_A,
        ST_CFG_R,
        ST_CFG_D,
        ST_POLL_WAIT,
        ST_RD_A,
        ST_RD_R,
        ST_RD_S,
        ST_RD_B,
        ST_ERR_STOP,
        ST_ERR_WAIT,
        ST_DIS_STOP
    } poll_state_t;

    typedef enum logic [1:0] {
        BO_IDLE,
        BO_ISSUE,
        BO_GUARD,
        BO_WAIT
    } byte_op_state_t;

endpackage

// File: rtl/i2c_byte_op.sv
// One byte operation against the i2c core: ISSUE (command for one cycle),
// GUARD (status ignored while the core reacts), WAIT (until busy clears).
module i2c_byte_op
    import i2c_poller_pkg::*;
(
    input  logic       I2C_clk,
    input  logic       arst_i,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] data,
    input  logic       core_busy,
    input  logic       core_nack,
    input  logic [7:0] receive,
    output logic [7:0] command,
    output logic [7:0] transmit,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata
);

    byte_op_state_t state, state_next;
    logic [7:0]     cmd_q;

    always_ff @(posedge I2C_clk or negedge arst_i) begin
        if (!arst_i) begin
            state    <= BO_IDLE;
            cmd_q    <= '0;
            transmit <= '0;
        end else begin
            state <= state_next;
            // transmit is loaded only here, so it holds until the next ISSUE
            if (start && state == BO_IDLE) begin
                cmd_q    <= cmd;
                transmit <= data;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BO_IDLE:  if (start) state_next = BO_ISSUE;
            BO_ISSUE: state_next = BO_GUARD;
            BO_GUARD: state_next = BO_WAIT;
            BO_WAIT:  if (!core_busy) state_next = BO_IDLE;
            default:  state_next = BO_IDLE;
        endcase
    end

    always_comb begin
        command = '0;
        done    = 1'b0;
        if (state == BO_ISSUE) command = cmd_q;
        if (state == BO_WAIT && !core_busy) done = 1'b1;
    end

    assign nack  = core_nack;
    assign rdata = receive;

endmodule

// File: rtl/i2c_sensor_poller.sv
// Transaction sequencer for the byte-level i2c master core: one config write,
// then periodic repeated-start burst reads assembled into a sample bus.
module i2c_sensor_poller
    import i2c_poller_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR  = 7'h1D,
    parameter logic [7:0]  CFG_REG   = 8'h16,
    parameter logic [7:0]  CFG_VAL   = 8'h05,
    parameter logic [7:0]  DATA_REG  = 8'h06,
    parameter int unsigned N_BYTES   = 3,
    parameter int unsigned POLL_DIV  = 100000,
    parameter logic [15:0] PRESCALE  = 16'd999,
    parameter int unsigned RETRY_DIV = 1000000
) (
    input  logic                   I2C_clk,
    input  logic                   arst_i,
    input  logic                   enable,
    output logic [15:0]            prescale,
    output logic [7:0]             control,
    output logic [7:0]             transmit,
    output logic [7:0]             command,
    input  logic [7:0]             receive,
    input  logic [7:0]             status,
    output logic [8*N_BYTES-1:0]   sample,
    output logic                   sample_valid,
    output logic                   init_done,
    output logic                   err,
    output logic [7:0]             err_count
);

    localparam int unsigned CNT_MAX    = (POLL_DIV > RETRY_DIV) ? POLL_DIV : RETRY_DIV;
    localparam int unsigned CW         = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] POLL_LOAD  = CW'(POLL_DIV - 1);
    localparam logic [CW-1:0] RETRY_LOAD = CW'(RETRY_DIV - 1);

    poll_state_t          state, state_next;
    logic                 op_active, bo_start, bo_done, bo_nack;
    logic [7:0]           bo_cmd, bo_data, bo_rdata;
    logic [2:0]           byte_idx;
    logic                 last_byte, is_op, is_write, adv, nack_hit;
    logic [8*N_BYTES-1:0] acc, acc_next;
    logic [CW-1:0]        cnt;
    logic                 status_unused;

    assign prescale      = PRESCALE;
    assign control       = 8'h80;
    assign status_unused = ^status[5:0];

    assign last_byte = (byte_idx == 3'(N_BYTES - 1));
    assign is_write  = state inside {ST_CFG_A, ST_CFG_R, ST_CFG_D, ST_RD_A, ST_RD_R, ST_RD_S};
    assign is_op     = is_write || (state inside {ST_RD_B, ST_ERR_STOP, ST_DIS_STOP});
    assign nack_hit  = bo_done && is_write && bo_nack;
    assign adv       = bo_done && !nack_hit;

    i2c_byte_op u_byte_op (
        .I2C_clk   (I2C_clk),
        .arst_i    (arst_i),
        .start     (bo_start),
        .cmd       (bo_cmd),
        .data      (bo_data),
        .core_busy (status[STAT_BUSY]),
        .core_nack (status[STAT_NACK]),
        .receive   (receive),
        .command   (command),
        .transmit  (transmit),
        .done      (bo_done),
        .nack      (bo_nack),
        .rdata     (bo_rdata)
    );

    always_ff @(posedge I2C_clk or negedge arst_i) begin
        if (!arst_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    // enable is only honoured at byte-op boundaries; an open transaction owes a STOP
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:      if (enable) state_next = ST_CFG_A;
            ST_CFG_A:     if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_CFG_R : ST_DIS_STOP;
            ST_CFG_R:     if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_CFG_D : ST_DIS_STOP;
            ST_CFG_D:     if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_POLL_WAIT : ST_IDLE;
            ST_POLL_WAIT: if (!enable) state_next = ST_IDLE;
                          else if (cnt == '0) state_next = ST_RD_A;
            ST_RD_A:      if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_RD_R : ST_DIS_STOP;
            ST_RD_R:      if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_RD_S : ST_DIS_STOP;
            ST_RD_S:      if (nack_hit) state_next = ST_ERR_STOP;
                          else if (adv) state_next = enable ? ST_RD_B : ST_DIS_STOP;
            ST_RD_B:      if (adv) begin
                              if (last_byte)   state_next = enable ? ST_POLL_WAIT : ST_IDLE;
                              else if (!enable) state_next = ST_DIS_STOP;
                          end
            ST_ERR_STOP:  if (bo_done) state_next = ST_ERR_WAIT;
            ST_ERR_WAIT:  if (!enable || cnt == '0) state_next = ST_IDLE;
            ST_DIS_STOP:  if (bo_done) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bo_cmd   = '0;
        bo_data  = '0;
        bo_start = is_op && !op_active;
        err      = (state == ST_ERR_STOP) && bo_start;
        unique case (state)
            ST_CFG_A:    begin bo_cmd = CMD_START_WR; bo_data = {SLV_ADDR, 1'b0}; end
            ST_CFG_R:    begin bo_cmd = CMD_WR;       bo_data = CFG_REG;          end
            ST_CFG_D:    begin bo_cmd = CMD_WR_STOP;  bo_data = CFG_VAL;          end
            ST_RD_A:     begin bo_cmd = CMD_START_WR; bo_data = {SLV_ADDR, 1'b0}; end
            ST_RD_R:     begin bo_cmd = CMD_WR;       bo_data = DATA_REG;         end
            ST_RD_S:     begin bo_cmd = CMD_START_WR; bo_data = {SLV_ADDR, 1'b1}; end
            ST_RD_B:     bo_cmd = last_byte ? CMD_RD_NACK_STOP : CMD_RD_ACK;
            ST_ERR_STOP: bo_cmd = CMD_STOP;
            ST_DIS_STOP: bo_cmd = CMD_STOP;
            default:     bo_cmd = '0;
        endcase
    end

    always_comb begin
        acc_next = acc;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (32'(byte_idx) == i) acc_next[8*i +: 8] = bo_rdata;
        end
    end

    // acc collects the burst; sample only ever sees a fully assembled burst
    always_ff @(posedge I2C_clk or negedge arst_i) begin
        if (!arst_i) begin
            op_active    <= 1'b0;
            byte_idx     <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            err_count    <= '0;
            cnt          <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (bo_start)     op_active <= 1'b1;
            else if (bo_done) op_active <= 1'b0;

            if (state != ST_RD_B)      byte_idx <= '0;
            else if (bo_done)          byte_idx <= byte_idx + 3'd1;

            if (state == ST_RD_B && bo_done) begin
                acc <= acc_next;
                if (last_byte) begin
                    sample       <= acc_next;
                    sample_valid <= 1'b1;
                end
            end

            if (state == ST_CFG_D && adv) init_done <= 1'b1;
            else if (err)                 init_done <= 1'b0;

            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (state_next == ST_POLL_WAIT && state != ST_POLL_WAIT)     cnt <= POLL_LOAD;
            else if (state_next == ST_ERR_WAIT && state != ST_ERR_WAIT) cnt <= RETRY_LOAD;
            else if (cnt != '0)                                        cnt <= cnt - CW'(1);
        end
    end

endmodule
